// File: rtl/payment_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : payment_arbiter
// Purpose  : Round-robin owner selection for a shared bill-payment engine.
// Revision : 1.0 - initial release
// ============================================================================
module payment_arbiter #(
  parameter int N_TERM  = 4,
  parameter int TIMEOUT = 1000,
  parameter int ID_W    = $clog2(N_TERM)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_TERM-1:0]     req,
  input  logic [8*N_TERM-1:0]   bill_amount,
  input  logic                  eng_done,
  input  logic [7:0]            eng_remaining,
  output logic [N_TERM-1:0]     gnt,
  output logic                  busy,
  output logic [ID_W-1:0]       active_id,
  output logic                  eng_start,
  output logic [7:0]            eng_amount,
  output logic                  eng_abort,
  output logic [N_TERM-1:0]     done,
  output logic [N_TERM-1:0]     abort,
  output logic [7:0]            result_amount
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_WAIT    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  localparam logic [N_TERM-1:0] c_ONE      = {{(N_TERM-1){1'b0}}, 1'b1};
  localparam logic [ID_W-1:0]   c_LAST_ID  = ID_W'(N_TERM - 1);
  localparam logic [15:0]       c_CNT_LAST = 16'(TIMEOUT - 1);

  state_t              r_state;
  logic [ID_W-1:0]     r_ptr;
  logic [15:0]         r_cnt;
  logic [N_TERM-1:0]   r_gnt;
  logic                r_busy;
  logic [ID_W-1:0]     r_active_id;
  logic                r_eng_start;
  logic [7:0]          r_eng_amount;
  logic                r_eng_abort;
  logic [N_TERM-1:0]   r_done;
  logic [N_TERM-1:0]   r_abort;
  logic [7:0]          r_result;

  logic                w_found;
  logic [ID_W-1:0]     w_sel;
  logic [ID_W-1:0]     w_idx;
  logic [N_TERM-1:0]   w_own;

  // Walk the request vector once starting at r_ptr, wrapping at N_TERM-1.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = r_ptr;
    for (int k = 0; k < N_TERM; k++) begin
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
      w_idx = (w_idx == c_LAST_ID) ? '0 : w_idx + 1'b1;
    end
  end

  assign w_own = c_ONE << r_active_id;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_ptr        <= '0;
      r_cnt        <= '0;
      r_gnt        <= '0;
      r_busy       <= 1'b0;
      r_active_id  <= '0;
      r_eng_start  <= 1'b0;
      r_eng_amount <= '0;
      r_eng_abort  <= 1'b0;
      r_done       <= '0;
      r_abort      <= '0;
      r_result     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_active_id  <= w_sel;
            r_eng_amount <= bill_amount[{w_sel, 3'b000} +: 8];
            r_gnt        <= c_ONE << w_sel;
            r_busy       <= 1'b1;
            r_eng_start  <= 1'b1;
            r_state      <= S_GRANT;
          end
        end
        S_GRANT: begin
          r_eng_start <= 1'b0;
          r_cnt       <= '0;
          r_state     <= S_WAIT;
        end
        S_WAIT: begin
          // Completion outranks withdrawal and timeout in the same cycle.
          if (eng_done) begin
            r_result <= eng_remaining;
            r_done   <= w_own;
            r_gnt    <= '0;
            r_state  <= S_RELEASE;
          end else if (!req[r_active_id] || (r_cnt == c_CNT_LAST)) begin
            r_result    <= '0;
            r_abort     <= w_own;
            r_eng_abort <= 1'b1;
            r_gnt       <= '0;
            r_state     <= S_RELEASE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_RELEASE: begin
          r_done      <= '0;
          r_abort     <= '0;
          r_eng_abort <= 1'b0;
          r_busy      <= 1'b0;
          r_ptr       <= (r_active_id == c_LAST_ID) ? '0 : r_active_id + 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt           = r_gnt;
  assign busy          = r_busy;
  assign active_id     = r_active_id;
  assign eng_start     = r_eng_start;
  assign eng_amount    = r_eng_amount;
  assign eng_abort     = r_eng_abort;
  assign done          = r_done;
  assign abort         = r_abort;
  assign result_amount = r_result;

endmodule
`default_nettype wire

// File: tb/tb_payment_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_payment_arbiter
// Purpose  : Vector table, corner sequences and random transactions vs model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_payment_arbiter;

  localparam int N  = 4;
  localparam int TO = 5;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req;
  logic [31:0]  bill_amount;
  logic         eng_done;
  logic [7:0]   eng_remaining;
  logic [3:0]   gnt;
  logic         busy;
  logic [1:0]   active_id;
  logic         eng_start;
  logic [7:0]   eng_amount;
  logic         eng_abort;
  logic [3:0]   done;
  logic [3:0]   abort;
  logic [7:0]   result_amount;

  int n_checks = 0;
  int n_fail   = 0;
  int m_ptr    = 0;

  payment_arbiter #(.N_TERM(N), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .bill_amount(bill_amount),
    .eng_done(eng_done), .eng_remaining(eng_remaining), .gnt(gnt),
    .busy(busy), .active_id(active_id), .eng_start(eng_start),
    .eng_amount(eng_amount), .eng_abort(eng_abort), .done(done),
    .abort(abort), .result_amount(result_amount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] reqm;
    logic [7:0] amt;
    logic [7:0] rem;
    int         done_at;
    int         wd_at;
    int         exp_id;
    int         exp_waits;
    bit         exp_done;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One full transaction, entered and left during an IDLE cycle.
  task automatic run_txn(input logic [3:0] reqm, input logic [31:0] bills,
                         input logic [7:0] rem_val, input int done_at, input int wd_at,
                         input int exp_id, input int exp_waits, input bit exp_done);
    logic [3:0] oh;
    logic [7:0] amt;
    logic [3:0] rq;
    oh  = 4'b0001 << exp_id;
    amt = bills[exp_id*8 +: 8];
    req = reqm;
    bill_amount = bills;
    eng_done = 1'b0;
    @(posedge clk); #1;
    chk("grant_gnt", gnt, oh);
    chk("grant_start", eng_start, 1);
    chk("grant_busy", busy, 1);
    chk("grant_id", active_id, exp_id);
    chk("grant_amount", eng_amount, amt);
    bill_amount = $urandom;
    eng_done = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    chk("wait_start_low", eng_start, 0);
    chk("wait_gnt", gnt, oh);
    for (int c = 1; c <= exp_waits; c++) begin
      rq = reqm;
      if (wd_at != 0 && c >= wd_at) rq[exp_id] = 1'b0;
      req = rq;
      eng_done = (c == done_at);
      eng_remaining = (c == done_at) ? rem_val : 8'($urandom);
      @(posedge clk); #1;
      if (c < exp_waits) chk("wait_hold", {busy, gnt, done, abort}, {1'b1, oh, 8'h00});
    end
    eng_done = 1'b0;
    req = 4'b0000;
    chk("rel_gnt", gnt, 0);
    chk("rel_busy", busy, 1);
    chk("rel_done", done, exp_done ? oh : 4'b0000);
    chk("rel_abort", abort, exp_done ? 4'b0000 : oh);
    chk("rel_eng_abort", eng_abort, !exp_done);
    chk("rel_result", result_amount, exp_done ? rem_val : 8'h00);
    chk("rel_amount_latched", eng_amount, amt);
    @(posedge clk); #1;
    chk("idle_quiet", {busy, gnt, done, abort, eng_abort, eng_start}, 0);
    m_ptr = (exp_id + 1) % N;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] bills;
    int d, w, id, waits;
    bit isdone;
    logic [3:0] rm;

    //           reqm    amt    rem   done wd  id waits done
    tbl[0]  = '{4'b1111, 8'h11, 8'h01, 2, 0, 0, 2, 1};
    tbl[1]  = '{4'b1111, 8'h22, 8'h02, 1, 0, 1, 1, 1};
    tbl[2]  = '{4'b1111, 8'h33, 8'h03, 3, 0, 2, 3, 1};
    tbl[3]  = '{4'b1111, 8'h44, 8'h04, 1, 0, 3, 1, 1};
    tbl[4]  = '{4'b1111, 8'h55, 8'h05, 1, 0, 0, 1, 1};
    tbl[5]  = '{4'b0010, 8'h64, 8'h00, 1, 0, 1, 1, 1};
    tbl[6]  = '{4'b0001, 8'h77, 8'h99, 0, 0, 0, 5, 0};
    tbl[7]  = '{4'b0100, 8'h88, 8'h42, 0, 3, 2, 3, 0};
    tbl[8]  = '{4'b0100, 8'h99, 8'h42, 3, 3, 2, 3, 1};
    tbl[9]  = '{4'b0101, 8'hAA, 8'h5A, 5, 0, 0, 5, 1};
    tbl[10] = '{4'b1001, 8'hBB, 8'h6B, 1, 0, 3, 1, 1};
    tbl[11] = '{4'b1010, 8'hCC, 8'h7C, 0, 1, 1, 1, 0};

    reset = 1'b0; req = 4'b0; bill_amount = 32'h0; eng_done = 1'b0; eng_remaining = 8'h0;
    #1 reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk("reset_outputs", {gnt, busy, active_id, eng_start, eng_amount, eng_abort, done, abort, result_amount}, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int r = 0; r < 12; r++) begin
      bills = $urandom;
      bills[tbl[r].exp_id*8 +: 8] = tbl[r].amt;
      run_txn(tbl[r].reqm, bills, tbl[r].rem, tbl[r].done_at, tbl[r].wd_at,
              tbl[r].exp_id, tbl[r].exp_waits, tbl[r].exp_done);
    end

    // Asynchronous reset in the middle of a WAIT owned by terminal 3.
    req = 4'b1000;
    @(posedge clk); #1;
    chk("rst_seq_gnt", gnt, 4'b1000);
    @(posedge clk); #1;
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    chk("rst_async_outputs", {gnt, busy, active_id, eng_start, eng_amount, eng_abort, done, abort, result_amount}, 0);
    @(posedge clk); #1;
    chk("rst_no_pulse", {done, abort, eng_abort}, 0);
    reset = 1'b0;
    req = 4'b0000;
    m_ptr = 0;
    @(posedge clk); #1;
    run_txn(4'b1001, 32'h12345678, 8'h3C, 1, 0, 0, 1, 1);

    // Random transactions predicted from the rotation and outcome rules.
    for (int t = 0; t < 60; t++) begin
      rm = 4'($urandom_range(1, 15));
      bills = $urandom;
      d = $urandom_range(0, TO);
      w = $urandom_range(0, TO + 1);
      id = -1;
      for (int k = 0; k < N; k++)
        if (id < 0 && rm[(m_ptr + k) % N]) id = (m_ptr + k) % N;
      waits = TO;
      isdone = 1'b0;
      if (w != 0 && w < waits) waits = w;
      if (d != 0 && d <= waits) begin
        waits = d;
        isdone = 1'b1;
      end
      run_txn(rm, bills, 8'($urandom), d, w, id, waits, isdone);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/payment_arbiter.md
# payment_arbiter

Round-robin arbiter that shares one bill-payment engine among `N_TERM` kiosk terminals. It grants the engine to one requesting terminal at a time and forwards that terminal's bill amount. It then pulses the engine's start input and waits for completion, a timeout, or a withdrawal of the request. Finally it returns a done or abort pulse to the owning terminal. It sits between the terminal front-ends and the payment FSM, and drives that FSM's `start_payment`, consumes its `payment_complete`, and forces `line_disconnected` recovery on abort.

## Interface
- `N_TERM`, default 4: number of terminals, legal range 2..8.
- `TIMEOUT`, default 1000: maximum WAIT cycles before abort, legal range 1..65535.
- `ID_W`, default `$clog2(N_TERM)`: width of `active_id`.

- `clk`, input, 1: single clock; all logic is rising-edge.
- `reset`, input, 1: asynchronous, active-high; clears all state immediately.
- `req`, input, N_TERM: per-terminal request level, held high until done or abort.
- `bill_amount`, input, 8*N_TERM: terminal i's amount on bits [8i+7:8i].
- `eng_done`, input, 1: engine `payment_complete`.
- `eng_remaining`, input, 8: engine `remaining_amount`.
- `gnt`, output, N_TERM: one-hot grant; all zeros when no terminal is granted.
- `busy`, output, 1: engine allocated.
- `active_id`, output, ID_W: index of the granted terminal.
- `eng_start`, output, 1: one-cycle `start_payment` pulse.
- `eng_amount`, output, 8: latched bill amount of the granted terminal.
- `eng_abort`, output, 1: one-cycle abort pulse to the engine.
- `done`, output, N_TERM: one-cycle completion pulse to the owner.
- `abort`, output, N_TERM: one-cycle abort pulse to the owner.
- `result_amount`, output, 8: `eng_remaining` captured at completion; 0 after an abort.

## Operation
- All outputs are registered. Reset values:
  - `gnt`, `done`, `abort`: all zeros.
  - `busy`, `eng_start`, `eng_abort`: 0.
  - `active_id`, `eng_amount`, `result_amount`: 0.
  - State is IDLE, priority pointer `ptr` = 0, wait counter = 0.
- States are IDLE, GRANT, WAIT, RELEASE.
- IDLE:
  - If any `req` bit is set, select the first set bit searching upward from `ptr` and wrapping modulo N_TERM. Call it i.
  - Latch i into `active_id` and `bill_amount[i]` into `eng_amount`, then go to GRANT.
  - Otherwise stay in IDLE.
- GRANT (exactly one cycle):
  - `gnt[i]`=1, `busy`=1, `eng_start`=1.
  - Clear the counter, then go to WAIT.
  - `eng_done` is ignored in this cycle.
- WAIT: `gnt[i]`=1, `busy`=1, `eng_start`=0. Evaluated in priority order:
  1. `eng_done`=1: capture `eng_remaining` into `result_amount`, mark outcome = done.
  2. `req[i]`=0 (withdrawal): mark outcome = abort.
  3. Counter == TIMEOUT-1: mark outcome = abort.
  4. Otherwise: increment the counter and stay.
  - Any outcome moves to RELEASE.
- RELEASE (exactly one cycle):
  - `gnt` = 0 and `busy`=1.
  - Outcome done: `done[i]`=1.
  - Outcome abort: `abort[i]`=1, `eng_abort`=1, `result_amount`=0.
  - `ptr` ← (i+1) mod N_TERM; go to IDLE.
- Round-robin fairness: a terminal that keeps `req` high after service is re-granted only when no other terminal in rotation order is requesting.
- Requests from terminals other than i are ignored outside IDLE; they are not queued, only sampled in IDLE.
- `bill_amount` changes after GRANT do not affect `eng_amount`.
- Counter width is 16 bits and cannot overflow because it stops at TIMEOUT-1.
- Reset asserted mid-transaction:
  - All outputs return to reset values at once; no `done`, `abort` or `eng_abort` pulse is produced.
  - The engine shares the same reset.

## Timing
- The request sampled high at rising edge E0 while in IDLE gives GRANT in cycle E0→E1: `gnt`, `eng_start` and `busy` are high in that cycle.
- WAIT begins at E1. `eng_done` sampled high at edge Ek gives RELEASE in cycle Ek→Ek+1, then IDLE at Ek+1.
- Minimum transaction is 3 cycles of `busy` (GRANT, one WAIT, RELEASE). The earliest next grant is 1 cycle after RELEASE.
- Timeout: with no `eng_done`, WAIT lasts exactly TIMEOUT cycles, then RELEASE with `abort`.
- Simultaneous `eng_done` and withdrawal or timeout in the same WAIT cycle: done wins.

## Test plan
- Single request, engine completes:
  - Stimulus: N_TERM=4, `req`=0010, `bill_amount[1]`=0x64, `eng_done` one cycle after GRANT with `eng_remaining`=0x00.
  - Required: `gnt`=0010 for 2 cycles, one `eng_start` pulse, `eng_amount`=0x64, `done`=0010 for 1 cycle, `result_amount`=0x00, `ptr`=2.
- Round-robin under contention:
  - Stimulus: `req`=1111 held, each transaction completed by `eng_done`.
  - Required: grant order 0,1,2,3,0; `busy` falls for exactly 1 cycle between transactions.
- Timeout:
  - Stimulus: TIMEOUT=5, `req`=0001, `eng_done` never asserted.
  - Required: exactly 5 WAIT cycles, then `abort`=0001 and `eng_abort`=1 for 1 cycle, `result_amount`=0.
- Withdrawal:
  - Stimulus: `req[2]` dropped on the 3rd WAIT cycle.
  - Required: RELEASE next cycle with `abort`=0100 and `eng_abort`=1. The same cycle with `eng_done`=1 instead yields `done`=0100 and no abort.
- Reset mid-WAIT:
  - Stimulus: assert `reset` asynchronously while `gnt`=1000.
  - Required: all outputs 0 immediately with no `done` or `abort` pulse. After release, `req`=1001 grants terminal 0 first (`ptr`=0).
